// File: rtl/spec_load_gate_ctrl.sv
// spec_load_gate_ctrl: age-accurate load gating against unresolved branches held in an in-order FIFO
module spec_load_gate_ctrl #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 7,
  parameter int NUM_LD = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fence_en_i,
  input  logic                    br_alloc_valid_i,
  input  logic [TAG_W-1:0]        br_alloc_tag_i,
  output logic                    br_alloc_ready_o,
  input  logic                    br_resolve_valid_i,
  input  logic [TAG_W-1:0]        br_resolve_tag_i,
  input  logic                    flush_i,
  input  logic [NUM_LD-1:0]       ld_req_valid_i,
  input  logic [NUM_LD*TAG_W-1:0] ld_req_tag_i,
  output logic [NUM_LD-1:0]       ld_grant_o,
  output logic [CW-1:0]           pending_cnt_o,
  output logic [15:0]             blocked_cnt_o
);
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [TAG_W-1:0] tag_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0] blocked_cnt_q, blocked_cnt_d;
  logic [NUM_LD-1:0] blocked;
  logic alloc, reclaim;

  // a is older than b when b is ahead of a by less than half the tag space
  function automatic logic older(input logic [TAG_W-1:0] a, input logic [TAG_W-1:0] b);
    logic [TAG_W-1:0] d;
    d = b - a;
    return (d != '0) && !d[TAG_W-1];
  endfunction

  assign br_alloc_ready_o = count_q != CW'(DEPTH);
  assign alloc = br_alloc_valid_i && br_alloc_ready_o;
  assign reclaim = (count_q != '0) && !valid_q[head_q];
  assign ld_grant_o = ld_req_valid_i & ~blocked;
  assign pending_cnt_o = count_q;
  assign blocked_cnt_o = blocked_cnt_q;

  always_comb begin
    blocked = '0;
    for (int i = 0; i < NUM_LD; i++)
      for (int e = 0; e < DEPTH; e++)
        if (fence_en_i && valid_q[e] && older(tag_q[e], ld_req_tag_i[i*TAG_W +: TAG_W]))
          blocked[i] = 1'b1;
  end

  always_comb begin
    valid_d = valid_q;
    tag_d = tag_q;
    for (int e = 0; e < DEPTH; e++)
      if (br_resolve_valid_i && tag_q[e] == br_resolve_tag_i) valid_d[e] = 1'b0;
    if (alloc) begin
      valid_d[tail_q] = 1'b1;
      tag_d[tail_q] = br_alloc_tag_i;
    end
    head_d = head_q + PW'(reclaim);
    tail_d = tail_q + PW'(alloc);
    count_d = count_q + CW'(alloc) - CW'(reclaim);
    if (flush_i) begin
      valid_d = '0;
      head_d = '0;
      tail_d = '0;
      count_d = '0;
    end
    blocked_cnt_d = (|(ld_req_valid_i & blocked) && blocked_cnt_q != 16'hFFFF) ? blocked_cnt_q + 16'd1 : blocked_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      blocked_cnt_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      blocked_cnt_q <= blocked_cnt_d;
    end
    tag_q <= tag_d;
  end
endmodule
